// File: rtl/s1_tx_pkg.sv
// -----------------------------------------------------------------------------
// s1_tx_pkg -- shared definitions for the S1 serial transmitter.
//   Packet layout constants, FSM state encoding and the packet parity helper.
//   Optional feature macro: S1_TX_PARITY_EN (adds the PAR state and one parity
//   bit per packet).
// -----------------------------------------------------------------------------
package s1_tx_pkg;

  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 18;
  localparam int NUM_WORDS = 8;
  localparam int PKT_BITS  = ADDR_W + DATA_W;

`ifdef S1_TX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif

  // Cycles from one packet's first bit to the next one's, including the gap.
  localparam int PKT_LEN   = PKT_BITS + PAR_BITS + 1;

  localparam int CNT_W     = 5;
  localparam logic [CNT_W-1:0]  ADDR_LAST = 5'd2;
  localparam logic [CNT_W-1:0]  DATA_LAST = 5'd17;
  localparam logic [ADDR_W-1:0] LAST_PKT  = 3'd7;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
`ifdef S1_TX_PARITY_EN
    ST_PAR  = 3'd3,
`endif
    ST_DONE = 3'd4
  } state_e;

`ifdef S1_TX_PARITY_EN
  // Odd parity: the transmitted bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [PKT_BITS-1:0] bits);
    return ~(^bits);
  endfunction
`endif

endpackage

// File: rtl/s1_piso.sv
// -----------------------------------------------------------------------------
// s1_piso -- 21-bit parallel-in / serial-out shifter, MSB first.
//   clk, rst : clock and synchronous active-high reset (clears the register)
//   load     : capture din (takes priority over shift)
//   shift    : shift left by one, sin enters at the LSB
//   din      : {address, data word}
//   sin      : serial fill bit
//   msb      : current MSB, taken straight from the register
// -----------------------------------------------------------------------------
module s1_piso
  import s1_tx_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [PKT_BITS-1:0] din,
  input  logic                sin,
  output logic                msb
);

  logic [PKT_BITS-1:0] sh_r;

  // Shift register: reset clear, parallel load, or left shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_r <= {PKT_BITS{1'b0}};
    end else if (load) begin
      sh_r <= din;
    end else if (shift) begin
      sh_r <= {sh_r[PKT_BITS-2:0], sin};
    end else begin
      sh_r <= sh_r;
    end
  end

  assign msb = sh_r[PKT_BITS-1];

endmodule

// File: rtl/s1_tx.sv
// -----------------------------------------------------------------------------
// s1_tx -- reads the 8-word register bank and sends each word as a serial
// packet: 3 address bits then 18 data bits, MSB first, framed by active-low
// sen, with one idle cycle between packets.
//   clk, rst : clock, synchronous active-high reset
//   S1_done  : high once all 8 packets are out, held until reset
//   RB1_RW   : bank read/write select, tied to read (1)
//   RB1_A    : bank word address (= packet index)
//   RB1_Q    : bank read data for RB1_A, same-cycle
//   sen      : serial enable, low while a packet bit is on sd
//   sd       : serial data
// Optional feature macro: S1_TX_PARITY_EN appends one odd-parity bit after
// the data bits of every packet.
// -----------------------------------------------------------------------------
module s1_tx
  import s1_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              S1_done,
  output logic              RB1_RW,
  output logic [ADDR_W-1:0] RB1_A,
  input  logic [DATA_W-1:0] RB1_Q,
  output logic              sen,
  output logic              sd
);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [CNT_W-1:0]   bit_cnt_nxt_s;
  logic [ADDR_W-1:0]  pkt_r;
  logic [ADDR_W-1:0]  pkt_nxt_s;
  logic               sen_r;
  logic               sen_nxt_s;
  logic               done_r;
  logic               done_nxt_s;
  logic               load_s;
  logic               shift_s;
  logic               sin_s;
  logic               last_pkt_s;

`ifdef S1_TX_PARITY_EN
  logic               par_r;
`endif

  assign last_pkt_s = (pkt_r == LAST_PKT);

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_LOAD;
      bit_cnt_r <= 5'd0;
      pkt_r     <= 3'd0;
      sen_r     <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      pkt_r     <= pkt_nxt_s;
      sen_r     <= sen_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

`ifdef S1_TX_PARITY_EN
  // Parity of the packet, computed from the same bits the shifter loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_r <= 1'b0;
    end else if (load_s) begin
      par_r <= odd_parity({pkt_r, RB1_Q});
    end else begin
      par_r <= par_r;
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        state_nxt_s = ST_ADDR;
      end
      ST_ADDR: begin
        if (bit_cnt_r == ADDR_LAST) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (bit_cnt_r == DATA_LAST) begin
`ifdef S1_TX_PARITY_EN
          state_nxt_s = ST_PAR;
`else
          if (last_pkt_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_LOAD;
          end
`endif
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef S1_TX_PARITY_EN
      ST_PAR: begin
        if (last_pkt_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
`endif
      ST_DONE: begin
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_LOAD;
      end
    endcase
  end

  // Datapath controls and next values of the registered outputs.
  always_comb begin
    load_s  = (state_r == ST_LOAD);
`ifdef S1_TX_PARITY_EN
    shift_s = (state_r == ST_ADDR) || (state_r == ST_DATA) || (state_r == ST_PAR);
`else
    shift_s = (state_r == ST_ADDR) || (state_r == ST_DATA);
`endif

    // Bit counter restarts at every state change.
    if (shift_s && (state_nxt_s == state_r)) begin
      bit_cnt_nxt_s = bit_cnt_r + 5'd1;
    end else begin
      bit_cnt_nxt_s = 5'd0;
    end

    // The packet index (and with it RB1_A) moves only on entry to LOAD,
    // which never happens after packet 7, so it cannot wrap.
    if ((state_nxt_s == ST_LOAD) && (state_r != ST_LOAD)) begin
      pkt_nxt_s = pkt_r + 3'd1;
    end else begin
      pkt_nxt_s = pkt_r;
    end

`ifdef S1_TX_PARITY_EN
    sen_nxt_s = !((state_nxt_s == ST_ADDR) || (state_nxt_s == ST_DATA) ||
                  (state_nxt_s == ST_PAR));
    // The bit shifted in on the first shift of a packet reaches the MSB
    // exactly 21 shifts later, i.e. right after the last data bit, so the
    // parity bit lands on sd with no extra mux. Later fill bits are zero,
    // leaving sd low in the following LOAD/DONE cycle.
    if ((state_r == ST_ADDR) && (bit_cnt_r == 5'd0)) begin
      sin_s = par_r;
    end else begin
      sin_s = 1'b0;
    end
`else
    sen_nxt_s = !((state_nxt_s == ST_ADDR) || (state_nxt_s == ST_DATA));
    // Zero fill empties the shifter after the last bit, so sd is low
    // whenever sen is high.
    sin_s     = 1'b0;
`endif

    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  s1_piso u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .shift (shift_s),
    .din   ({pkt_r, RB1_Q}),
    .sin   (sin_s),
    .msb   (sd)
  );

  assign sen     = sen_r;
  assign S1_done = done_r;
  assign RB1_A   = pkt_r;
  assign RB1_RW  = 1'b1;

endmodule

// File: tb/tb_s1_tx.sv
// Directed bench for s1_tx: reset state, a table of hand-computed output
// values at chosen edges, a serial receiver rebuilding the bank, and
// hand-written reset-in-DONE / mid-packet reset sequences.
module tb_s1_tx;
  import s1_tx_pkg::*;

`ifdef S1_TX_PARITY_EN
  localparam int DONE_E = 184;
  localparam int RXB    = 22;
`else
  localparam int DONE_E = 176;
  localparam int RXB    = 21;
`endif

  typedef struct {
    int         edge_n;
    logic       sen;
    logic       sd;
    logic       done;
    logic [2:0] a;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        s1_done;
  logic        rb1_rw;
  logic [2:0]  rb1_a;
  logic [17:0] rb1_q;
  logic        sen;
  logic        sd;

  logic [17:0] bank    [0:7];
  logic [17:0] rx_bank [0:7];
  vec_t        vecs[$];

  int          n_cmp;
  int          n_err;
  int          rx_cnt;
  int          rx_pkts;
  logic [21:0] rx_sh;
  int          first_done;
  int          rw_bad;
  int          done_bad;

  assign rb1_q = bank[rb1_a];

  s1_tx dut (
    .clk     (clk),
    .rst     (rst),
    .S1_done (s1_done),
    .RB1_RW  (rb1_rw),
    .RB1_A   (rb1_a),
    .RB1_Q   (rb1_q),
    .sen     (sen),
    .sd      (sd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int e, input logic s, input logic d, input logic dn, input logic [2:0] a);
    vec_t v;
    v.edge_n = e; v.sen = s; v.sd = d; v.done = dn; v.a = a;
    vecs.push_back(v);
  endtask

  // Serial receiver: collects bits while sen is low, files the word on gap.
  task automatic rx_step();
    logic [2:0]  ra;
    logic [17:0] rd;
    if (sen === 1'b0) begin
      rx_sh  = {rx_sh[20:0], sd};
      rx_cnt = rx_cnt + 1;
    end else if (rx_cnt != 0) begin
      chk("rx_len", rx_cnt, RXB);
`ifdef S1_TX_PARITY_EN
      ra = rx_sh[21:19];
      rd = rx_sh[18:1];
      chk("rx_par", {31'd0, rx_sh[0]}, {31'd0, ~(^{ra, rd})});
`else
      ra = rx_sh[20:18];
      rd = rx_sh[17:0];
`endif
      chk("rx_addr", {29'd0, ra}, rx_pkts);
      rx_bank[ra] = rd;
      rx_pkts = rx_pkts + 1;
      rx_cnt  = 0;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; rx_cnt = 0; rx_pkts = 0; rx_sh = 22'd0;
    first_done = 0; rw_bad = 0; done_bad = 0;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bank[i]    = 18'h3FFFF - 18'(i);
      rx_bank[i] = 18'd0;
    end
    bank[5] = 18'h2AAAA;

`ifdef S1_TX_PARITY_EN
    bank[0] = 18'h00001;
    bank[1] = 18'h00000;
    add(1,   1'b0, 1'b0, 1'b0, 3'd0);
    add(4,   1'b0, 1'b0, 1'b0, 3'd0);
    add(21,  1'b0, 1'b1, 1'b0, 3'd0);
    add(22,  1'b0, 1'b0, 1'b0, 3'd0);
    add(23,  1'b1, 1'b0, 1'b0, 3'd1);
    add(24,  1'b0, 1'b0, 1'b0, 3'd1);
    add(26,  1'b0, 1'b1, 1'b0, 3'd1);
    add(44,  1'b0, 1'b0, 1'b0, 3'd1);
    add(45,  1'b0, 1'b0, 1'b0, 3'd1);
    add(46,  1'b1, 1'b0, 1'b0, 3'd2);
    add(116, 1'b0, 1'b1, 1'b0, 3'd5);
    add(117, 1'b0, 1'b0, 1'b0, 3'd5);
    add(118, 1'b0, 1'b1, 1'b0, 3'd5);
    add(119, 1'b0, 1'b1, 1'b0, 3'd5);
    add(137, 1'b0, 1'b0, 1'b0, 3'd5);
    add(138, 1'b1, 1'b0, 1'b0, 3'd6);
    add(183, 1'b0, 1'b1, 1'b0, 3'd7);
    add(184, 1'b1, 1'b0, 1'b1, 3'd7);
    add(200, 1'b1, 1'b0, 1'b1, 3'd7);
`else
    add(1,   1'b0, 1'b0, 1'b0, 3'd0);
    add(3,   1'b0, 1'b0, 1'b0, 3'd0);
    add(4,   1'b0, 1'b1, 1'b0, 3'd0);
    add(21,  1'b0, 1'b1, 1'b0, 3'd0);
    add(22,  1'b1, 1'b0, 1'b0, 3'd1);
    add(23,  1'b0, 1'b0, 1'b0, 3'd1);
    add(25,  1'b0, 1'b1, 1'b0, 3'd1);
    add(43,  1'b0, 1'b0, 1'b0, 3'd1);
    add(44,  1'b1, 1'b0, 1'b0, 3'd2);
    add(64,  1'b0, 1'b0, 1'b0, 3'd2);
    add(65,  1'b0, 1'b1, 1'b0, 3'd2);
    add(111, 1'b0, 1'b1, 1'b0, 3'd5);
    add(112, 1'b0, 1'b0, 1'b0, 3'd5);
    add(113, 1'b0, 1'b1, 1'b0, 3'd5);
    add(114, 1'b0, 1'b1, 1'b0, 3'd5);
    add(115, 1'b0, 1'b0, 1'b0, 3'd5);
    add(131, 1'b0, 1'b0, 1'b0, 3'd5);
    add(132, 1'b1, 1'b0, 1'b0, 3'd6);
    add(153, 1'b0, 1'b1, 1'b0, 3'd6);
    add(155, 1'b0, 1'b1, 1'b0, 3'd7);
    add(172, 1'b0, 1'b1, 1'b0, 3'd7);
    add(173, 1'b0, 1'b0, 1'b0, 3'd7);
    add(175, 1'b0, 1'b0, 1'b0, 3'd7);
    add(176, 1'b1, 1'b0, 1'b1, 3'd7);
    add(200, 1'b1, 1'b0, 1'b1, 3'd7);
`endif

    // Reset state.
    repeat (3) tick();
    chk("rst_sen",  {31'd0, sen},     32'd1);
    chk("rst_sd",   {31'd0, sd},      32'd0);
    chk("rst_done", {31'd0, s1_done}, 32'd0);
    chk("rst_a",    {29'd0, rb1_a},   32'd0);
    chk("rst_rw",   {31'd0, rb1_rw},  32'd1);
    rst = 1'b0;

    // Full run: table vectors, receiver, global invariants.
    for (int e = 1; e <= 200; e++) begin
      tick();
      foreach (vecs[i]) begin
        if (vecs[i].edge_n == e) begin
          chk($sformatf("e%0d_sen", e),  {31'd0, sen},     {31'd0, vecs[i].sen});
          chk($sformatf("e%0d_sd", e),   {31'd0, sd},      {31'd0, vecs[i].sd});
          chk($sformatf("e%0d_done", e), {31'd0, s1_done}, {31'd0, vecs[i].done});
          chk($sformatf("e%0d_a", e),    {29'd0, rb1_a},   {29'd0, vecs[i].a});
        end
      end
      rx_step();
      if (rb1_rw !== 1'b1) rw_bad++;
      if ((first_done == 0) && (s1_done === 1'b1)) first_done = e;
      if ((first_done != 0) && ((sen !== 1'b1) || (sd !== 1'b0) ||
                                (rb1_a !== 3'd7) || (s1_done !== 1'b1))) done_bad++;
    end
    chk("done_edge", first_done, DONE_E);
    chk("rw_const",  rw_bad,     32'd0);
    chk("done_hold", done_bad,   32'd0);
    chk("rx_pkts",   rx_pkts,    32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rx_word%0d", i), {14'd0, rx_bank[i]}, {14'd0, bank[i]});
    end

    // Reset while in DONE clears S1_done at that edge.
    rst = 1'b1;
    tick();
    chk("dnrst_done", {31'd0, s1_done}, 32'd0);
    chk("dnrst_sen",  {31'd0, sen},     32'd1);
    chk("dnrst_a",    {29'd0, rb1_a},   32'd0);
    rst = 1'b0;

    // Reset mid-packet (packet 2 data) at edge 50.
    for (int e = 1; e <= 49; e++) tick();
    chk("mid_pre_sen", {31'd0, sen},   32'd0);
    chk("mid_pre_a",   {29'd0, rb1_a}, 32'd2);
    rst = 1'b1;
    tick();
    chk("mid_sen",  {31'd0, sen},     32'd1);
    chk("mid_sd",   {31'd0, sd},      32'd0);
    chk("mid_a",    {29'd0, rb1_a},   32'd0);
    chk("mid_done", {31'd0, s1_done}, 32'd0);
    rst = 1'b0;
    tick();
    chk("restart_sen", {31'd0, sen},   32'd0);
    chk("restart_sd",  {31'd0, sd},    32'd0);
    chk("restart_a",   {29'd0, rb1_a}, 32'd0);
    for (int e = 2; e <= DONE_E; e++) begin
      tick();
      if (e == DONE_E - 1) chk("restart_done_pre", {31'd0, s1_done}, 32'd0);
      if (e == DONE_E)     chk("restart_done",     {31'd0, s1_done}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
